fir_sequencer: RTL and testbench

Controller that sequences the single-port, combinational-read waveform/kernel ROM to compute a valid-mode FIR convolution of the stored waveform. Caches the NUM_TAPS-entry kernel from KERNEL_BASE into registers, then walks the waveform at WAVE_BASE. Each output is a signed multiply-accumulate, normalised by an arithmetic right shift and saturated. Results are streamed out over a valid/ready handshake to the picoMIPS datapath or testbench sink.

---
 rtl/fir_sequencer_if.sv | 40 ++++
 rtl/fir_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_fir_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_sequencer_if.sv
// ----------------------------------------------------------------------------
// fir_sequencer_if
// Bundles the two buses of the FIR sequencer:
//   - ROM read bus    : rom_addr (sequencer -> ROM), rom_data (ROM -> sequencer,
//                       combinational from rom_addr, signed)
//   - output stream   : out_valid/out_data/out_index (sequencer -> sink),
//                       out_ready (sink -> sequencer)
// Modports:
//   master : the sequencer side
//   slave  : the ROM/sink side (testbench or picoMIPS datapath)
// ----------------------------------------------------------------------------
interface fir_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic        [ADDR_WIDTH-1:0] rom_addr;
    logic signed [DATA_WIDTH-1:0] rom_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic        [ADDR_WIDTH-1:0] out_index;

    modport master (
        output rom_addr,
        input  rom_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index
    );
endinterface

// File: rtl/fir_sequencer.sv
// ----------------------------------------------------------------------------
// fir_sequencer
// Valid-mode FIR convolution sequencer over a single-port ROM. The kernel
// (NUM_TAPS words at KERNEL_BASE) is cached into registers, then for every
// output n the waveform at WAVE_BASE+n+k is multiplied against tap k and
// accumulated. Each result is arithmetically shifted right by SHIFT,
// saturated to DATA_WIDTH and streamed out over a valid/ready handshake.
//
// Ports:
//   clk    - system clock, all state on the rising edge
//   reset  - asynchronous, active-high reset
//   start  - one-cycle request for a full pass (only honoured in IDLE)
//   busy   - high from the cycle after start is accepted until back in IDLE
//   done   - one-cycle pulse after the last output has been accepted
//   bus    - fir_sequencer_if.master: ROM read bus and output stream
//
// Build option:
//   FIR_ROUND_EN - when defined, 2^(SHIFT-1) is added before the shift
//                  (round-half-up); otherwise the shift truncates.
//                  Handshake and timing are the same in both builds.
// ----------------------------------------------------------------------------
module fir_sequencer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] KERNEL_BASE = 8'h00,
    parameter int                    NUM_TAPS    = 5,
    parameter logic [ADDR_WIDTH-1:0] WAVE_BASE   = 8'h10,
    parameter int                    NUM_SAMPLES = 16,
    parameter int                    ACC_WIDTH   = 20,
    parameter int                    SHIFT       = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    fir_sequencer_if.master bus
);

    localparam int KW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [KW-1:0]         LAST_TAP = KW'(NUM_TAPS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_OUT = ADDR_WIDTH'(NUM_SAMPLES - NUM_TAPS);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2**(DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2**(DATA_WIDTH-1)));
`ifdef FIR_ROUND_EN
    localparam logic signed [ACC_WIDTH:0] ROUND_C = (ACC_WIDTH+1)'(2**(SHIFT-1));
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_K = 3'd1,
        MAC    = 3'd2,
        OUT    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                       state_r, state_s;
    logic        [ADDR_WIDTH-1:0] rom_addr_r, rom_addr_s;
    logic        [KW-1:0]         k_r, k_s;
    logic        [ADDR_WIDTH-1:0] n_r, n_s;
    logic signed [ACC_WIDTH-1:0]  acc_r, acc_s;
    logic                         out_valid_r, out_valid_s;
    logic signed [DATA_WIDTH-1:0] out_data_r, out_data_s;
    logic        [ADDR_WIDTH-1:0] out_index_r, out_index_s;
    logic                         busy_r, busy_s;
    logic                         done_r, done_s;
    logic                         load_en_s;
    logic signed [DATA_WIDTH-1:0] taps_r [NUM_TAPS];

    logic                         last_tap_s;
    logic signed [PW-1:0]         prod_s;
    logic signed [ACC_WIDTH-1:0]  acc_sum_s;

    // Normalise (optionally rounded) and clamp to the signed output range.
    // The extra guard bit keeps the rounding add from overflowing.
    function automatic logic signed [DATA_WIDTH-1:0] norm_sat(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH:0] wide;
        logic signed [ACC_WIDTH:0] sh;
`ifdef FIR_ROUND_EN
        wide = {a[ACC_WIDTH-1], a} + ROUND_C;
`else
        wide = {a[ACC_WIDTH-1], a};
`endif
        sh = wide >>> SHIFT;
        if (sh > SAT_MAX) begin
            norm_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (sh < SAT_MIN) begin
            norm_sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            norm_sat = sh[DATA_WIDTH-1:0];
        end
    endfunction

    assign last_tap_s = (k_r == LAST_TAP);
    // Signed 8x8 product, sign-extended into the accumulator width.
    assign prod_s     = taps_r[k_r] * bus.rom_data;
    assign acc_sum_s  = acc_r + {{(ACC_WIDTH-PW){prod_s[PW-1]}}, prod_s};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = LOAD_K;
                else       state_s = IDLE;
            end
            LOAD_K: begin
                if (last_tap_s) state_s = MAC;
                else            state_s = LOAD_K;
            end
            MAC: begin
                if (last_tap_s) state_s = OUT;
                else            state_s = MAC;
            end
            OUT: begin
                if (out_valid_r && bus.out_ready) begin
                    if (n_r == LAST_OUT) state_s = DONE;
                    else                 state_s = MAC;
                end else begin
                    state_s = OUT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath. rom_addr is
    // always loaded one cycle ahead so the combinational ROM word lines up
    // with the tap index of the cycle that consumes it.
    always_comb begin
        rom_addr_s  = rom_addr_r;
        k_s         = k_r;
        n_s         = n_r;
        acc_s       = acc_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_index_s = out_index_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        load_en_s   = 1'b0;
        case (state_r)
            IDLE: begin
                rom_addr_s = KERNEL_BASE;
                k_s        = '0;
                if (start) busy_s = 1'b1;
                else       busy_s = 1'b0;
            end
            LOAD_K: begin
                load_en_s = 1'b1;
                if (last_tap_s) begin
                    k_s        = '0;
                    n_s        = '0;
                    acc_s      = '0;
                    rom_addr_s = WAVE_BASE;
                end else begin
                    k_s        = k_r + KW'(1);
                    rom_addr_s = rom_addr_r + ADDR_WIDTH'(1);
                end
            end
            MAC: begin
                acc_s = acc_sum_s;
                if (last_tap_s) begin
                    // Present the result straight from the final sum so the
                    // output appears on the same edge as the last product.
                    k_s         = '0;
                    out_valid_s = 1'b1;
                    out_data_s  = norm_sat(acc_sum_s);
                    out_index_s = n_r;
                end else begin
                    k_s        = k_r + KW'(1);
                    rom_addr_s = rom_addr_r + ADDR_WIDTH'(1);
                end
            end
            OUT: begin
                if (out_valid_r && bus.out_ready) begin
                    out_valid_s = 1'b0;
                    if (n_r == LAST_OUT) begin
                        done_s = 1'b1;
                    end else begin
                        n_s        = n_r + ADDR_WIDTH'(1);
                        acc_s      = '0;
                        k_s        = '0;
                        rom_addr_s = WAVE_BASE + n_r + ADDR_WIDTH'(1);
                    end
                end else begin
                    out_valid_s = out_valid_r;
                end
            end
            DONE: begin
                busy_s     = 1'b0;
                rom_addr_s = KERNEL_BASE;
            end
            default: begin
                busy_s      = 1'b0;
                out_valid_s = 1'b0;
                rom_addr_s  = KERNEL_BASE;
            end
        endcase
    end

    // Datapath and output registers, including the cached kernel taps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_r  <= KERNEL_BASE;
            k_r         <= '0;
            n_r         <= '0;
            acc_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_index_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                taps_r[i] <= '0;
            end
        end else begin
            rom_addr_r  <= rom_addr_s;
            k_r         <= k_s;
            n_r         <= n_s;
            acc_r       <= acc_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_index_r <= out_index_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            if (load_en_s) begin
                taps_r[k_r] <= bus.rom_data;
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign bus.rom_addr  = rom_addr_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_index = out_index_r;

endmodule

// File: tb/tb_fir_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fir_sequencer
// Directed bench for fir_sequencer with a behavioural combinational ROM.
// A table of {kernel, waveform, expected outputs} records is run as full
// passes, followed by hand-written sequences for backpressure, latency and
// start filtering, start-coincident-with-done, and reset in the middle of MAC.
// ----------------------------------------------------------------------------
module tb_fir_sequencer;

    localparam int NT = 5;
    localparam int NS = 16;
    localparam int NO = NS - NT + 1;
    localparam int KBASE = 0;
    localparam int WBASE = 16;

`ifdef FIR_ROUND_EN
    localparam logic [7:0] C_CONST = 8'h10;
    localparam logic [7:0] C_IMP0 = 8'd17;
    localparam logic [7:0] C_IMP1 = 8'd29;
    localparam logic [7:0] C_IMP2 = 8'd35;
`else
    localparam logic [7:0] C_CONST = 8'h0F;
    localparam logic [7:0] C_IMP0 = 8'd16;
    localparam logic [7:0] C_IMP1 = 8'd28;
    localparam logic [7:0] C_IMP2 = 8'd34;
`endif

    typedef struct packed {
        logic [NT-1:0][7:0] kern;
        logic [NS-1:0][7:0] wave;
        logic [NO-1:0][7:0] expv;
    } vec_t;

    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic [7:0] rom [0:255];
    vec_t vecs [4];
    int checks;
    int errors;

    fir_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

    assign bus.rom_data = rom[bus.rom_addr];

    fir_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_rom(input int v);
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int k = 0; k < NT; k++) rom[KBASE + k] = vecs[v].kern[k];
        for (int i = 0; i < NS; i++) rom[WBASE + i] = vecs[v].wave[i];
    endtask

    // Wait (bounded) for out_valid, counting falling edges.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.out_valid && cyc < 200);
    endtask

    task automatic recv(input string tag, input int n, input logic [7:0] dexp);
        int c;
        wait_valid(c);
        check($sformatf("%s_valid_n%0d", tag, n), {31'd0, bus.out_valid}, 32'd1);
        check($sformatf("%s_index_n%0d", tag, n), $unsigned(bus.out_index), n);
        check($sformatf("%s_data_n%0d", tag, n), $unsigned(bus.out_data), {24'd0, dexp});
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 50);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pass(input int v);
        load_rom(v);
        pulse_start();
        for (int n = 0; n < NO; n++) begin
            recv($sformatf("v%0d", v), n, vecs[v].expv[n]);
        end
        wait_done($sformatf("v%0d", v));
    endtask

    initial begin : main
        int c;
        int cyc;
        int first_v;
        int last_v;
        int nval;
        int done_c;

        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b1;

        // Vector table: constant, impulse, negative full-scale, saturation.
        vecs[0].kern = {8'd17, 8'd29, 8'd35, 8'd29, 8'd17};
        vecs[0].wave = {NS{8'h10}};
        vecs[0].expv = {NO{C_CONST}};

        vecs[1].kern = {8'd17, 8'd29, 8'd35, 8'd29, 8'd17};
        vecs[1].wave = '0;
        vecs[1].wave[4] = 8'h7F;
        vecs[1].expv = '0;
        vecs[1].expv[0] = C_IMP0;
        vecs[1].expv[1] = C_IMP1;
        vecs[1].expv[2] = C_IMP2;
        vecs[1].expv[3] = C_IMP1;
        vecs[1].expv[4] = C_IMP0;

        vecs[2].kern = {8'd17, 8'd29, 8'd35, 8'd29, 8'd17};
        vecs[2].wave = {NS{8'h80}};
        vecs[2].expv = {NO{8'h81}};

        // Kernel all 127; waveform 8x +127 then 8x -128: clamps high,
        // one unsaturated result (124), then clamps low.
        vecs[3].kern = {NT{8'h7F}};
        for (int i = 0; i < NS; i++) vecs[3].wave[i] = (i < 8) ? 8'h7F : 8'h80;
        for (int i = 0; i < NO; i++) vecs[3].expv[i] = (i < 5) ? 8'h7F : ((i == 5) ? 8'h7C : 8'h80);

        load_rom(0);
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_rom_addr", $unsigned(bus.rom_addr), KBASE);
        check("rst_out_data", $unsigned(bus.out_data), 32'd0);
        check("rst_out_index", $unsigned(bus.out_index), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 4; v++) run_pass(v);

        // Backpressure at n=2: everything holds for 3 cycles.
        load_rom(1);
        pulse_start();
        recv("bp", 0, vecs[1].expv[0]);
        recv("bp", 1, vecs[1].expv[1]);
        wait_valid(c);
        check("bp_valid_n2", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_valid_%0d", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("bp_hold_data_%0d", i), $unsigned(bus.out_data), {24'd0, vecs[1].expv[2]});
            check($sformatf("bp_hold_index_%0d", i), $unsigned(bus.out_index), 32'd2);
            check($sformatf("bp_hold_addr_%0d", i), $unsigned(bus.rom_addr), WBASE + 2 + NT - 1);
        end
        bus.out_ready = 1'b1;
        wait_valid(c);
        check("bp_next_latency", c, NT + 1);
        check("bp_next_index", $unsigned(bus.out_index), 32'd3);
        check("bp_next_data", $unsigned(bus.out_data), {24'd0, vecs[1].expv[3]});
        for (int n = 4; n < NO; n++) recv("bp", n, vecs[1].expv[n]);
        wait_done("bp");

        // Latency, pass length, and a start pulse while busy. Cycle 0 is
        // the cycle in which start is high.
        load_rom(0);
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        first_v = 0;
        last_v = 0;
        nval = 0;
        done_c = 0;
        while (done_c == 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc == 4) start = 1'b1;
            if (cyc == 5) start = 1'b0;
            if (bus.out_valid) begin
                if (nval == 0) first_v = cyc;
                last_v = cyc;
                check($sformatf("tm_index_%0d", nval), $unsigned(bus.out_index), nval);
                nval++;
            end
            if (done) done_c = cyc;
        end
        check("tm_first_valid", first_v, 2 * NT + 1);
        check("tm_num_outputs", nval, NO);
        check("tm_last_valid", last_v, NT + NO * (NT + 1));
        check("tm_done_cycle", done_c, NT + NO * (NT + 1) + 1);

        // start coincident with done is ignored; next cycle it is accepted.
        start = 1'b1;
        @(negedge clk);
        check("sd_ignored_busy", {31'd0, busy}, 32'd0);
        check("sd_ignored_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("sd_accepted_busy", {31'd0, busy}, 32'd1);

        // Reset in the middle of the MAC phase for n=3.
        recv("rs", 0, vecs[0].expv[0]);
        recv("rs", 1, vecs[0].expv[1]);
        recv("rs", 2, vecs[0].expv[2]);
        repeat (2) @(negedge clk);
        check("rs_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rs_busy", {31'd0, busy}, 32'd0);
        check("rs_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rs_done", {31'd0, done}, 32'd0);
        check("rs_rom_addr", $unsigned(bus.rom_addr), KBASE);
        check("rs_out_index", $unsigned(bus.out_index), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_pass(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
